// File: rtl/gas_comp_unit.sv
// ---------------------------------------------------------------------------
// gas_comp_unit
//
// Per-item graph-analytics compute step followed by a small output FIFO.
// Every accepted item is evaluated in the cycle it is accepted:
//   PROCESS_EDGE : result = data_a,              flag = 0
//   REDUCE_MIN   : result = unsigned min(a, b),  flag = 0
//   REDUCE_ADD   : result = a + b (carry lost),  flag = 0
//   APPLY        : result = data_a,              flag = (a != b)
// The {flag, result} pair is then written into a DEPTH-entry FIFO. The
// outputs are driven from the FIFO head, so an item accepted in cycle N is
// visible in cycle N+1. With DROP_UNCHANGED=1, APPLY items whose flag is 0
// are counted as dropped and never enter the FIFO.
//
// Parameters
//   DATA_WIDTH     operand/result width, 8..128
//   DEPTH          FIFO entries, power of two, 2..64
//   DROP_UNCHANGED discard APPLY items with flag=0 when 1
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   data_a/data_b  operands
//   mode_i         0 PROCESS_EDGE, 1 REDUCE_MIN, 2 REDUCE_ADD, 3 APPLY
//   valid_i/ready_o   input handshake (ready_o depends on occupancy only)
//   valid_o/ready_i   output handshake
//   data_o/flag_o  FIFO head result and update flag
//   occ_o          number of buffered items
//   in_cnt_o       accepted items (including dropped), saturating
//   drop_cnt_o     dropped items, saturating
// ---------------------------------------------------------------------------
module gas_comp_unit #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 4,
  parameter bit DROP_UNCHANGED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     data_a,
  input  logic [DATA_WIDTH-1:0]     data_b,
  input  logic [1:0]                mode_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      flag_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    occ_o,
  output logic [31:0]               in_cnt_o,
  output logic [31:0]               drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MODE_PROCESS_EDGE = 2'd0,
    MODE_REDUCE_MIN   = 2'd1,
    MODE_REDUCE_ADD   = 2'd2,
    MODE_APPLY        = 2'd3
  } mode_e;

  mode_e                 mode;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_flag;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  drop_item;
  logic                  enq;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_next;
  logic [31:0]           in_cnt;
  logic [31:0]           drop_cnt;

  // Each entry holds {flag, data}.
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   head;

  assign mode = mode_e'(mode_i);

  // -------------------------------------------------------------------------
  // Per-item compute
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    res_data = '0;
    res_flag = 1'b0;
    case (mode)
      MODE_PROCESS_EDGE: res_data = data_a;
      MODE_REDUCE_MIN:   res_data = (data_a < data_b) ? data_a : data_b;
      MODE_REDUCE_ADD:   res_data = data_a + data_b;
      MODE_APPLY: begin
        res_data = data_a;
        res_flag = (data_a != data_b);
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // ready_o comes from occupancy alone: a full FIFO refuses input even when
  // the head is leaving this cycle, which keeps ready_i off the input path.
  assign ready_o   = (occ != FULL_OCC);
  assign valid_o   = (occ != '0);
  assign in_xfer   = valid_i & ready_o;
  assign out_xfer  = valid_o & ready_i;
  assign drop_item = DROP_UNCHANGED && (mode == MODE_APPLY) && !res_flag;
  assign enq       = in_xfer & ~drop_item;

  always_comb begin
    occ_next = occ;
    case ({enq, out_xfer})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control state: pointers, occupancy, counters
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      in_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      // Pointers are exactly PTR_W bits wide, so the increment wraps
      // modulo DEPTH on its own.
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (out_xfer) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ_next;
      if (in_xfer && (in_cnt != CNT_MAX))
        in_cnt <= in_cnt + 32'd1;
      if (in_xfer && drop_item && (drop_cnt != CNT_MAX))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents are only observable
  // through entries counted by occ, and occ is reset, so stale data can never
  // reach the outputs; leaving it unreset keeps it plain RAM-style storage.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {res_flag, res_data};
  end

  assign head = mem[rd_ptr];

  // The head entry is registered state; it is masked while the FIFO is empty
  // so data_o/flag_o read 0 out of reset and never show stale entries.
  assign data_o     = valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign flag_o     = valid_o ? head[DATA_WIDTH]     : 1'b0;
  assign occ_o      = occ;
  assign in_cnt_o   = in_cnt;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_gas_comp_unit.sv
// ---------------------------------------------------------------------------
// tb_gas_comp_unit
//
// Self-checking bench for gas_comp_unit (DATA_WIDTH=64, DEPTH=4).
// Instance dut keeps every item; instance dut_d discards unchanged APPLY
// items. dut is compared every cycle against a queue-based model of the
// item stream; dut_d is checked with directed expectations.
// ---------------------------------------------------------------------------
module tb_gas_comp_unit;

  localparam int DW  = 64;
  localparam int DEP = 4;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  // Main instance signals
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic [1:0]    mode_i = 2'd0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          flag_o;
  logic          ready_i = 1'b0;
  logic [2:0]    occ_o;
  logic [31:0]   in_cnt_o;
  logic [31:0]   drop_cnt_o;

  // Dropping instance signals
  logic [DW-1:0] a_d = '0;
  logic [DW-1:0] b_d = '0;
  logic [1:0]    mode_d = 2'd0;
  logic          valid_d = 1'b0;
  logic          ready_od;
  logic          valid_od;
  logic [DW-1:0] data_od;
  logic          flag_od;
  logic          ready_id = 1'b0;
  logic [2:0]    occ_od;
  logic [31:0]   in_cnt_od;
  logic [31:0]   drop_cnt_od;

  int checks = 0;
  int errors = 0;

  // Reference model state: queued {flag, data} items and accepted count.
  logic [64:0] q[$];
  int          m_in = 0;

  always #5 clk = ~clk;

  gas_comp_unit #(.DATA_WIDTH(DW), .DEPTH(DEP), .DROP_UNCHANGED(1'b0)) dut (
    .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
    .mode_i(mode_i), .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .flag_o(flag_o),
    .ready_i(ready_i), .occ_o(occ_o), .in_cnt_o(in_cnt_o),
    .drop_cnt_o(drop_cnt_o)
  );

  gas_comp_unit #(.DATA_WIDTH(DW), .DEPTH(DEP), .DROP_UNCHANGED(1'b1)) dut_d (
    .clk(clk), .rst(rst), .data_a(a_d), .data_b(b_d),
    .mode_i(mode_d), .valid_i(valid_d), .ready_o(ready_od),
    .valid_o(valid_od), .data_o(data_od), .flag_o(flag_od),
    .ready_i(ready_id), .occ_o(occ_od), .in_cnt_o(in_cnt_od),
    .drop_cnt_o(drop_cnt_od)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {flag, data} for one item, straight from the operation table.
  function automatic logic [64:0] expect_item(input logic [1:0] m,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
    logic [64:0] sum;
    case (m)
      2'd0:    return {1'b0, a};
      2'd1:    return {1'b0, (a < b) ? a : b};
      2'd2:    begin sum = {1'b0, a} + {1'b0, b}; return {1'b0, sum[63:0]}; end
      default: return {(a != b), a};
    endcase
  endfunction

  task automatic check_model();
    check("valid_o", {63'd0, valid_o}, {63'd0, q.size() > 0});
    check("ready_o", {63'd0, ready_o}, {63'd0, q.size() < DEP});
    check("occ_o", {61'd0, occ_o}, 64'(q.size()));
    check("in_cnt_o", {32'd0, in_cnt_o}, 64'(m_in));
    check("drop_cnt_o", {32'd0, drop_cnt_o}, 64'd0);
    if (q.size() > 0) begin
      check("data_o", data_o, q[0][63:0]);
      check("flag_o", {63'd0, flag_o}, {63'd0, q[0][64]});
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic rs, input logic v, input logic [1:0] m,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic r);
    bit acc;
    bit pop;
    rst = rs; valid_i = v; mode_i = m; data_a = a; data_b = b; ready_i = r;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_in = 0;
    end else begin
      acc = v && (q.size() < DEP);
      pop = (q.size() > 0) && r;
      if (pop) void'(q.pop_front());
      if (acc) begin
        m_in++;
        q.push_back(expect_item(m, a, b));
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [1:0]  mseq [4];
    mseq[0] = 2'd0; mseq[1] = 2'd3; mseq[2] = 2'd1; mseq[3] = 2'd2;

    // Reset state
    cycle(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    check("rst_data_o", data_o, 64'd0);
    check("rst_flag_o", {63'd0, flag_o}, 64'd0);
    check("rst_ready_o", {63'd0, ready_o}, 64'd1);
    check("rst_d_occ", {61'd0, occ_od}, 64'd0);

    // Fill with ready_i low: 4 accepted, 5th refused
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, 1'b1, 2'd2, 64'(i), 64'd1, 1'b0);
    check("full_in_cnt", {32'd0, in_cnt_o}, 64'd4);
    check("full_occ", {61'd0, occ_o}, 64'd4);
    check("full_ready", {63'd0, ready_o}, 64'd0);
    check("full_head", data_o, 64'd2);

    // Full FIFO, push and pop every cycle: no bubbles, order kept
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            {$urandom, $urandom}, 1'b1);
      check("stream_valid", {63'd0, valid_o}, 64'd1);
      check("stream_occ_le4", {63'd0, occ_o <= 3'd4}, 64'd1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);

    // Add wraps, min is unsigned
    cycle(1'b0, 1'b1, 2'd2, ALL1, 64'd2, 1'b0);
    check("add_wrap_data", data_o, 64'd1);
    check("add_wrap_flag", {63'd0, flag_o}, 64'd0);
    cycle(1'b0, 1'b1, 2'd1, 64'd5, 64'd3, 1'b1);
    check("min_data", data_o, 64'd3);
    cycle(1'b0, 1'b1, 2'd1, ALL1, 64'd9, 1'b1);
    check("min_unsigned", data_o, 64'd9);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);

    // One-cycle latency, then reset overriding a simultaneous transfer
    cycle(1'b0, 1'b1, 2'd0, 64'hABCD, 64'd0, 1'b0);
    check("latency_valid", {63'd0, valid_o}, 64'd1);
    check("latency_data", data_o, 64'hABCD);
    cycle(1'b1, 1'b1, 2'd0, 64'h1234, 64'd0, 1'b0);
    check("midrst_valid", {63'd0, valid_o}, 64'd0);
    check("midrst_occ", {61'd0, occ_o}, 64'd0);
    check("midrst_in_cnt", {32'd0, in_cnt_o}, 64'd0);
    check("midrst_drop_cnt", {32'd0, drop_cnt_o}, 64'd0);

    // Interleaved modes 0,3,1,2 with random valid/ready
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 1) == 1) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ra >> 1;
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), mseq[i % 4], ra, rb,
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);
    check("drain_empty", {63'd0, valid_o}, 64'd0);

    // Dropping instance: (7,7) (7,8) (9,9) in APPLY mode
    cycle(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    valid_d = 1'b1; mode_d = 2'd3; ready_id = 1'b0;
    a_d = 64'd7; b_d = 64'd7;
    cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    check("drop1_occ", {61'd0, occ_od}, 64'd0);
    check("drop1_cnt", {32'd0, drop_cnt_od}, 64'd1);
    a_d = 64'd7; b_d = 64'd8;
    cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    a_d = 64'd9; b_d = 64'd9;
    cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    valid_d = 1'b0;
    check("drop_occ", {61'd0, occ_od}, 64'd1);
    check("drop_valid", {63'd0, valid_od}, 64'd1);
    check("drop_data", data_od, 64'd7);
    check("drop_flag", {63'd0, flag_od}, 64'd1);
    check("drop_cnt", {32'd0, drop_cnt_od}, 64'd2);
    check("drop_in_cnt", {32'd0, in_cnt_od}, 64'd3);
    ready_id = 1'b1;
    cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    check("drop_popped", {63'd0, valid_od}, 64'd0);
    check("drop_ready", {63'd0, ready_od}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_comp_unit.md
GAS_COMP_UNIT -- requirements
Module: gas_comp_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning operand/result width in bits (legal range 8..128).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning output buffer entries (power of two, legal range 2..64).
REQ-003 The block SHALL have parameter DROP_UNCHANGED, default 0, meaning that when 1, APPLY results with flag=0 are discarded instead of buffered.
REQ-004 The block SHALL have the following ports, in order (clock and reset first):
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_a  input  DATA_WIDTH  operand A.
- data_b  input  DATA_WIDTH  operand B.
- mode_i  input  2  operation: 0 PROCESS_EDGE, 1 REDUCE_MIN, 2 REDUCE_ADD, 3 APPLY.
- valid_i  input  1  upstream item valid.
- ready_o  output  1  block can accept an item.
- valid_o  output  1  output item valid.
- data_o  output  DATA_WIDTH  result.
- flag_o  output  1  update flag (APPLY only; 0 otherwise).
- ready_i  input  1  downstream accepts output item.
- occ_o  output  log2(DEPTH)+1  buffered item count.
- in_cnt_o  output  32  accepted-item counter.
- drop_cnt_o  output  32  dropped-item counter.

Function
REQ-005 An input transfer SHALL occur on a cycle where valid_i=1 and ready_o=1; an output transfer SHALL occur on a cycle where valid_o=1 and ready_i=1.
REQ-006 The result SHALL be computed from data_a, data_b and mode_i sampled on the input-transfer cycle; mode is per-item and may change every cycle.
REQ-007 PROCESS_EDGE SHALL produce data_o=data_a, flag_o=0.
REQ-008 REDUCE_MIN SHALL produce the unsigned minimum of data_a and data_b, flag_o=0.
REQ-009 REDUCE_ADD SHALL produce (data_a+data_b) mod 2^DATA_WIDTH (carry discarded), flag_o=0.
REQ-010 APPLY SHALL produce data_o=data_a and flag_o=(data_a!=data_b).
REQ-011 Results SHALL be stored in a DEPTH-entry FIFO; data_o/flag_o SHALL be driven from the FIFO head register, never combinationally from inputs.
REQ-012 Latency SHALL be exactly 1 cycle: an item accepted in cycle N into an empty FIFO SHALL present valid_o=1 in cycle N+1.
REQ-013 ready_o SHALL be 1 iff occ_o<DEPTH (registered state only; no combinational path from ready_i).
REQ-014 Simultaneous input and output transfer SHALL leave occ_o unchanged and preserve FIFO order; at occ_o=DEPTH no input transfer occurs even if ready_i=1.
REQ-015 valid_o SHALL be 1 iff occ_o>0; data_o/flag_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-016 With DROP_UNCHANGED=1, an accepted APPLY item with flag=0 SHALL not be enqueued and SHALL increment drop_cnt_o; ready_o still follows REQ-013.
REQ-017 in_cnt_o SHALL increment by 1 on every input transfer, including dropped items; both counters SHALL saturate at 2^32-1.
REQ-018 Sustained throughput SHALL be one item per cycle when ready_i=1 continuously.
REQ-019 FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-020 While rst=1: occ_o=0, valid_o=0, ready_o=1 (first cycle after release), data_o=0, flag_o=0, in_cnt_o=0, drop_cnt_o=0; all FIFO contents discarded.
REQ-021 rst asserted mid-operation SHALL take priority over any simultaneous transfer; no transfer is counted in that cycle.

Verification
REQ-022 DEPTH=4, ready_i=0, push 5 items mode 2 (a=i, b=1) -> ready_o=0 after 4th, occ_o=4, 5th not accepted, in_cnt_o=4.
REQ-023 Mode 2, a=2^64-1, b=2 -> data_o=1, flag_o=0; mode 1, a=5, b=3 -> data_o=3.
REQ-024 Full FIFO, valid_i=1 and ready_i=1 every cycle for 20 cycles -> 20 outputs in order, no bubbles after drain starts, occ_o never exceeds 4.
REQ-025 DROP_UNCHANGED=1, mode 3 items (7,7),(7,8),(9,9) -> one output data_o=7 flag_o=1, drop_cnt_o=2, in_cnt_o=3.
REQ-026 Empty FIFO, push item in cycle N -> valid_o=1 in N+1; rst in N+2 with ready_i=0 -> valid_o=0, occ_o=0, counters 0 in N+3.
REQ-027 Interleaved modes 0,3,1,2 back-to-back with random ready_i -> output sequence matches scoreboard model per item mode.
